seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter n, default 4, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port sgn, input, 1 bit: operand interpretation, 0 = unsigned, 1 = two's-complement signed; captured with start.
REQ-006 SHALL have port A, input, n bits: multiplicand; captured with start.
REQ-007 SHALL have port B, input, n bits: multiplier; captured with start.
REQ-008 SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-010 SHALL have port Product, output, 2n bits: result, held stable until the next accepted start.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-012 In IDLE with start=1 at edge k, SHALL capture A, B and sgn, clear the accumulator, and enter CALC at k+1.
REQ-013 In IDLE with start=0, SHALL remain in IDLE.
REQ-014 With sgn=1, SHALL operate on the magnitudes of A and B and record the result sign as the XOR of the two sign bits.
REQ-015 In CALC, SHALL perform exactly one shift-add iteration per cycle, for n cycles, using a cycle counter of width clog2(n+1).
REQ-016 After the n-th iteration, SHALL enter DONE, apply the recorded sign by negating the result when it is 1, and load Product.
REQ-017 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-018 Latency from the start edge to done high SHALL be n+1 cycles; the earliest next accepted start is n+2 cycles after the first.
REQ-019 SHALL drive busy=1 in CALC only; busy and done SHALL never be high together.
REQ-020 SHALL ignore start in CALC and DONE; no capture, and the operation in progress is unaffected.
REQ-021 Changes to A, B or sgn after capture SHALL NOT affect the result.
REQ-022 The result SHALL be exact with no overflow: the unsigned maximum (2^n-1)^2 and the signed extreme (-2^(n-1))^2 = 2^(2n-2) both fit in 2n bits.
REQ-023 When either operand is zero, Product SHALL be 0 for both signs, with no -0 artefact.
REQ-024 Product SHALL change only on entry to DONE or on reset.

Reset
REQ-025 While rst_n=0, SHALL force the state to IDLE, busy=0, done=0, Product=0, and clear the counter and accumulator, independent of clk.
REQ-026 A reset asserted during CALC SHALL abort the operation; no done pulse follows, and after release the block waits in IDLE for a new start.
REQ-027 The first start edge SHALL be accepted on the first clk edge after rst_n rises.

Structure
REQ-028 A shared package mul_pkg SHALL hold the state enum type (IDLE, CALC, DONE) and the legal-range constants for n.
REQ-029 One sub-module, mul_abs (n-bit conditional two's-complement negate with an enable), SHALL be instantiated for operand magnitudes; a 2n-bit instance SHALL apply the result sign.
REQ-030 SHALL contain no combinational path from any input to any output.

Verification (n=4)
REQ-031 SHALL verify: sgn=0, A=4'hF, B=4'hF, start pulse at edge k -> busy high at k+1..k+4, done=1 at k+5, Product=8'hE1 (225).
REQ-032 SHALL verify: sgn=1, A=4'b1000 (-8), B=4'b1000 -> Product=8'h40 (+64); sgn=1, A=4'hD (-3), B=4'h5 -> Product=8'hF1 (-15).
REQ-033 SHALL verify: sgn=0, A=4'h3, B=4'h2, then start re-pulsed with A=4'hF during CALC -> one done only, Product=8'h06.
REQ-034 SHALL verify: rst_n pulled low at cycle 2 of CALC -> busy=0 and Product=0 immediately, no done pulse; a subsequent A=2, B=1 gives Product=8'h02.
REQ-035 SHALL verify: sgn=1, A=4'h0, B=4'h9 -> Product=8'h00; back-to-back start at the earliest legal edge (k+6) -> two done pulses exactly 6 cycles apart.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter must be able to hold the value n itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_abs.sv
// Conditional two's-complement negate: dout = en ? -din : din.
module mul_abs #(
    parameter int W = 4
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential n x n shift-add multiplier with optional signed operands.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; operands and sign captured on start
//   CALC  | one shift-add iteration per cycle, n iterations, busy high
//   DONE  | Product loaded on entry, done high for this single cycle
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int n = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sgn,
    input  logic [n-1:0]   A,
    input  logic [n-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*n-1:0] Product
);

    localparam int CW = cnt_width(n);

    state_e          state_q, state_d;
    logic [2*n-1:0]  mcand_q, mcand_d;
    logic [n-1:0]    mplier_q, mplier_d;
    logic [2*n-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2*n-1:0]  product_q, product_d;

    logic [n-1:0]    a_mag;
    logic [n-1:0]    b_mag;
    logic [2*n-1:0]  acc_step;
    logic [2*n-1:0]  prod_signed;

    mul_abs #(.W(n)) u_abs_a (
        .en   (sgn & A[n-1]),
        .din  (A),
        .dout (a_mag)
    );

    mul_abs #(.W(n)) u_abs_b (
        .en   (sgn & B[n-1]),
        .din  (B),
        .dout (b_mag)
    );

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Negating a zero magnitude yields zero, so no -0 can appear.
    mul_abs #(.W(2*n)) u_abs_p (
        .en   (sign_q),
        .din  (acc_step),
        .dout (prod_signed)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    mcand_d  = {{n{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    sign_d   = sgn & (A[n-1] ^ B[n-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(n);
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                // Final iteration: load the signed result in the same edge.
                if (cnt_q == CW'(1)) begin
                    product_d = prod_signed;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench for seq_multiplier against an arithmetic reference.
module tb_seq_multiplier;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           sgn;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*N-1:0] Product;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2*N-1:0] last_exp;

    seq_multiplier #(.n(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sgn     (sgn),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Product (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact product from plain integer arithmetic, truncated to 2N bits.
    function automatic logic [2*N-1:0] ref_mul(input bit s, input logic [N-1:0] a, input logic [N-1:0] b);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({1'b0, a}) * longint'({1'b0, b});
        return p[2*N-1:0];
    endfunction

    // Stimulus only: runs one operation and reports what it observed.
    task automatic do_op(input bit s, input logic [N-1:0] a, input logic [N-1:0] b, input bit scramble,
                         output logic [2*N-1:0] got, output int edges, output int busy_cycles,
                         output int overlap, output logic [2*N-1:0] prod_at_start, output logic done_after);
        sgn = s; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        if (scramble) begin
            A = N'($urandom); B = N'($urandom); sgn = 1'($urandom);
        end
        prod_at_start = Product;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        overlap = 0;
        edges = 0;
        while (done !== 1'b1 && edges < N + 4) begin
            tick();
            edges++;
            if (busy === 1'b1) busy_cycles++;
            if (busy === 1'b1 && done === 1'b1) overlap++;
        end
        got = Product;
        tick();
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; A = '0; B = '0;
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (Product !== '0) begin n_bad++; $display("FAIL reset_product got=%h want=0", Product); end
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = '0;
    endtask

    task automatic test_unsigned_max();
        logic [2*N-1:0] got, pas; int e, bc, ov; logic da;
        do_op(1'b0, 4'hF, 4'hF, 1'b0, got, e, bc, ov, pas, da);
        n_cmp++; if (got !== 8'hE1) begin n_bad++; $display("FAIL umax_product got=%h want=e1", got); end
        n_cmp++; if (e !== N) begin n_bad++; $display("FAIL umax_latency got=%0d want=%0d", e, N); end
        n_cmp++; if (bc !== N) begin n_bad++; $display("FAIL umax_busy_cycles got=%0d want=%0d", bc, N); end
        n_cmp++; if (ov !== 0) begin n_bad++; $display("FAIL umax_busy_done_overlap got=%0d want=0", ov); end
        n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL umax_done_pulse got=%b want=0", da); end
        last_exp = 8'hE1;
    endtask

    task automatic test_signed();
        logic [2*N-1:0] got, pas; int e, bc, ov; logic da;
        do_op(1'b1, 4'b1000, 4'b1000, 1'b0, got, e, bc, ov, pas, da);
        n_cmp++; if (got !== 8'h40) begin n_bad++; $display("FAIL signed_min_sq got=%h want=40", got); end
        n_cmp++; if (pas !== last_exp) begin n_bad++; $display("FAIL signed_hold got=%h want=%h", pas, last_exp); end
        do_op(1'b1, 4'hD, 4'h5, 1'b0, got, e, bc, ov, pas, da);
        n_cmp++; if (got !== 8'hF1) begin n_bad++; $display("FAIL signed_neg got=%h want=f1", got); end
        n_cmp++; if (pas !== 8'h40) begin n_bad++; $display("FAIL signed_hold2 got=%h want=40", pas); end
        last_exp = 8'hF1;
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        logic [2*N-1:0] got = '0;
        sgn = 1'b0; A = 4'h3; B = 4'h2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        A = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3 * N + 4; i++) begin
            if (done === 1'b1) begin dones++; got = Product; end
            tick();
        end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
        n_cmp++; if (got !== 8'h06) begin n_bad++; $display("FAIL ignore_product got=%h want=06", got); end
        last_exp = 8'h06;
    endtask

    task automatic test_reset_abort();
        int e = 0;
        sgn = 1'b0; A = 4'h7; B = 4'h3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        n_cmp++; if (Product !== '0) begin n_bad++; $display("FAIL abort_product got=%h want=0", Product); end
        for (int i = 0; i < N + 2; i++) begin
            tick();
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done got=%b want=0", done); end
        end
        sgn = 1'b0; A = 4'h2; B = 4'h1; start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL first_start_accept got=%b want=1", busy); end
        while (done !== 1'b1 && e < N + 4) begin tick(); e++; end
        n_cmp++; if (e !== N) begin n_bad++; $display("FAIL after_reset_latency got=%0d want=%0d", e, N); end
        n_cmp++; if (Product !== 8'h02) begin n_bad++; $display("FAIL after_reset_product got=%h want=02", Product); end
        tick();
        last_exp = 8'h02;
    endtask

    task automatic test_back_to_back();
        int e = 0, t1, t2;
        logic [N-1:0] a2, b2;
        logic s2;
        a2 = N'($urandom); b2 = N'($urandom); s2 = 1'($urandom);
        sgn = 1'b1; A = 4'h0; B = 4'h9; start = 1'b1;
        tick();
        A = a2; B = b2; sgn = s2;
        while (done !== 1'b1 && e < N + 4) begin tick(); e++; end
        t1 = e;
        n_cmp++; if (Product !== 8'h00) begin n_bad++; $display("FAIL zero_product got=%h want=00", Product); end
        tick(); e++;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_single_pulse got=%b want=0", done); end
        while (done !== 1'b1 && e < 3 * N + 8) begin tick(); e++; end
        t2 = e;
        start = 1'b0;
        n_cmp++; if (t2 - t1 !== N + 2) begin n_bad++; $display("FAIL b2b_spacing got=%0d want=%0d", t2 - t1, N + 2); end
        n_cmp++; if (Product !== ref_mul(s2, a2, b2)) begin
            n_bad++; $display("FAIL b2b_product got=%h want=%h", Product, ref_mul(s2, a2, b2));
        end
        tick();
        last_exp = ref_mul(s2, a2, b2);
    endtask

    task automatic test_random();
        logic [2*N-1:0] got, pas, exp_p; int e, bc, ov; logic da;
        logic [N-1:0] a, b; bit s;
        for (int i = 0; i < 40; i++) begin
            a = N'($urandom); b = N'($urandom); s = 1'($urandom);
            if (i % 10 == 0) a = '0;
            exp_p = ref_mul(s, a, b);
            do_op(s, a, b, 1'b1, got, e, bc, ov, pas, da);
            n_cmp++; if (got !== exp_p) begin n_bad++; $display("FAIL rand_product s=%0d a=%h b=%h got=%h want=%h", s, a, b, got, exp_p); end
            n_cmp++; if (e !== N) begin n_bad++; $display("FAIL rand_latency got=%0d want=%0d", e, N); end
            n_cmp++; if (bc !== N) begin n_bad++; $display("FAIL rand_busy_cycles got=%0d want=%0d", bc, N); end
            n_cmp++; if (ov !== 0) begin n_bad++; $display("FAIL rand_overlap got=%0d want=0", ov); end
            n_cmp++; if (pas !== last_exp) begin n_bad++; $display("FAIL rand_hold got=%h want=%h", pas, last_exp); end
            last_exp = exp_p;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
